// File: rtl/l2_cache_response_queue_pkg.sv
// Shared L2 request/response packet types, op encodings and cache geometry
// used by the L2 writeback and response stages.
package l2_cache_response_queue_pkg;

  localparam int NUM_CORES          = 4;
  localparam int L1_WAY_INDEX_WIDTH = 2;
  localparam int CACHE_LINE_BITS    = 128;
  localparam int ADDR_WIDTH         = 32;
  localparam int CORE_ID_WIDTH      = $clog2(NUM_CORES);
  localparam int UNIT_WIDTH         = 2;
  localparam int STRAND_WIDTH       = 2;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_LOAD_SYNC   = 3'd5,
    L2REQ_STORE_SYNC  = 3'd6
  } l2req_op_t;

  typedef enum logic [1:0] {
    L2RSP_LOAD_ACK    = 2'd0,
    L2RSP_STORE_ACK   = 2'd1,
    L2RSP_DINVALIDATE = 2'd2,
    L2RSP_IINVALIDATE = 2'd3
  } l2rsp_op_t;

  typedef struct packed {
    logic                          valid;
    logic [CORE_ID_WIDTH-1:0]      core;
    logic [UNIT_WIDTH-1:0]         unit;
    logic [STRAND_WIDTH-1:0]       strand;
    l2req_op_t                     op;
    logic [ADDR_WIDTH-1:0]         address;
    logic [L1_WAY_INDEX_WIDTH-1:0] way;
  } l2req_packet_t;

  typedef struct packed {
    logic                                    valid;
    logic                                    status;
    logic [CORE_ID_WIDTH-1:0]                core;
    logic [UNIT_WIDTH-1:0]                   unit;
    logic [STRAND_WIDTH-1:0]                 strand;
    l2rsp_op_t                               op;
    logic [NUM_CORES-1:0]                    update;
    logic [NUM_CORES*L1_WAY_INDEX_WIDTH-1:0] way;
    logic [ADDR_WIDTH-1:0]                   address;
    logic [CACHE_LINE_BITS-1:0]              data;
  } l2rsp_packet_t;

  // Maintenance ops answer even when the line missed in the L2.
  function automatic logic l2req_forces_response(input l2req_op_t op);
    return (op == L2REQ_FLUSH) || (op == L2REQ_DINVALIDATE) || (op == L2REQ_IINVALIDATE);
  endfunction

endpackage

// File: rtl/l2_response_fifo.sv
// Generic synchronous FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle. Output reads as all-zero while empty.
module l2_response_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so
  // stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/l2_cache_response_queue.sv
// L2 response stage: builds a response per qualifying request and queues it
// behind ready/valid backpressure. Optional checking: L2RSP_OVERFLOW_CHECK_EN.
module l2_cache_response_queue
  import l2_cache_response_queue_pkg::*;
#(
  parameter int NUM_CORES          = l2_cache_response_queue_pkg::NUM_CORES,
  parameter int L1_WAY_INDEX_WIDTH = l2_cache_response_queue_pkg::L1_WAY_INDEX_WIDTH,
  parameter int FIFO_DEPTH         = 8,
  parameter int PIPE_SLACK         = 3
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  l2req_packet_t                           wr_l2req_packet,
  input  logic [CACHE_LINE_BITS-1:0]              wr_data,
  input  logic [NUM_CORES-1:0]                    wr_l1_has_line,
  input  logic [NUM_CORES*L1_WAY_INDEX_WIDTH-1:0] wr_dir_l1_way,
  input  logic                                    wr_cache_hit,
  input  logic                                    wr_is_l2_fill,
  input  logic                                    wr_store_sync_success,
  output l2rsp_packet_t                           l2rsp_packet,
  input  logic                                    l2rsp_ready,
  output logic                                    almost_full,
  output logic                                    overflow
);

  localparam int L2RSP_PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int L2RSP_CNT_WIDTH = L2RSP_PTR_WIDTH + 1;
  localparam logic [L2RSP_CNT_WIDTH-1:0] AF_THRESHOLD = L2RSP_CNT_WIDTH'(FIFO_DEPTH - PIPE_SLACK);

  l2rsp_packet_t              w_rsp;
  logic                       w_qualify;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;
  logic                       w_push_ok;
  logic [L2RSP_CNT_WIDTH-1:0] w_count;
  logic [L2RSP_CNT_WIDTH-1:0] w_next_count;
  logic                       r_almost_full;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rsp         = '0;
    w_qualify     = wr_l2req_packet.valid &&
                    (wr_cache_hit || wr_is_l2_fill || l2req_forces_response(wr_l2req_packet.op));
    w_rsp.valid   = 1'b1;
    w_rsp.status  = 1'b1;
    w_rsp.core    = wr_l2req_packet.core;
    w_rsp.unit    = wr_l2req_packet.unit;
    w_rsp.strand  = wr_l2req_packet.strand;
    w_rsp.address = wr_l2req_packet.address;
    w_rsp.data    = wr_data;
    w_rsp.op      = L2RSP_LOAD_ACK;
    case (wr_l2req_packet.op)
      L2REQ_STORE_SYNC: begin
        w_rsp.op     = L2RSP_STORE_ACK;
        w_rsp.status = wr_store_sync_success;
        w_rsp.update = wr_l1_has_line & {NUM_CORES{wr_store_sync_success}};
      end
      L2REQ_STORE: begin
        w_rsp.op     = L2RSP_STORE_ACK;
        w_rsp.update = wr_l1_has_line;
      end
      L2REQ_DINVALIDATE: begin
        w_rsp.op     = L2RSP_DINVALIDATE;
        w_rsp.update = wr_l1_has_line;
      end
      L2REQ_IINVALIDATE: w_rsp.op = L2RSP_IINVALIDATE;
      default:           w_rsp.op = L2RSP_LOAD_ACK;
    endcase
    for (int i = 0; i < NUM_CORES; i++) begin
      w_rsp.way[i*L1_WAY_INDEX_WIDTH +: L1_WAY_INDEX_WIDTH] =
        wr_l1_has_line[i] ? wr_dir_l1_way[i*L1_WAY_INDEX_WIDTH +: L1_WAY_INDEX_WIDTH]
                          : wr_l2req_packet.way;
    end
  end

  assign w_pop        = !w_empty && l2rsp_ready;
  assign w_push_ok    = w_qualify && (!w_full || w_pop);
  assign w_next_count = w_count + L2RSP_CNT_WIDTH'(w_push_ok) - L2RSP_CNT_WIDTH'(w_pop);

  l2_response_fifo #(
    .WIDTH ($bits(l2rsp_packet_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_qualify),
    .i_data  (w_rsp),
    .i_pop   (w_pop),
    .o_data  (l2rsp_packet),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_almost_full <= 1'b0;
    else          r_almost_full <= (w_next_count >= AF_THRESHOLD);
  end

  assign almost_full = r_almost_full;

`ifdef L2RSP_OVERFLOW_CHECK_EN
  localparam logic [7:0] SLACK_CYCLES = 8'(PIPE_SLACK);
  logic       r_overflow;
  logic [7:0] r_af_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_af_cycles <= '0;
    end else begin
      if (w_qualify && w_full && !w_pop) r_overflow <= 1'b1;
      if (!r_almost_full)          r_af_cycles <= '0;
      else if (r_af_cycles != '1)  r_af_cycles <= r_af_cycles + 1'b1;
    end
  end

  assign overflow = r_overflow;

  a_no_drop: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_qualify && w_full && !w_pop));
  // Upstream may still issue PIPE_SLACK in-flight requests after the stall.
  a_slack_respected: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_qualify && (r_af_cycles >= SLACK_CYCLES)));
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_l2_cache_response_queue.sv
// Self-checking bench for l2_cache_response_queue: directed scenarios then
// random traffic, checked against a queue-based reference model.
module tb_l2_cache_response_queue;
  import l2_cache_response_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int SLACK = 3;
  localparam int PKT_W = $bits(l2rsp_packet_t);
  localparam int WW    = L1_WAY_INDEX_WIDTH;

  logic                          clk;
  logic                          reset_n;
  l2req_packet_t                 wr_l2req_packet;
  logic [CACHE_LINE_BITS-1:0]    wr_data;
  logic [NUM_CORES-1:0]          wr_l1_has_line;
  logic [NUM_CORES*WW-1:0]       wr_dir_l1_way;
  logic                          wr_cache_hit;
  logic                          wr_is_l2_fill;
  logic                          wr_store_sync_success;
  l2rsp_packet_t                 l2rsp_packet;
  logic                          l2rsp_ready;
  logic                          almost_full;
  logic                          overflow;

  l2_cache_response_queue #(
    .NUM_CORES          (NUM_CORES),
    .L1_WAY_INDEX_WIDTH (WW),
    .FIFO_DEPTH         (DEPTH),
    .PIPE_SLACK         (SLACK)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .wr_l2req_packet       (wr_l2req_packet),
    .wr_data               (wr_data),
    .wr_l1_has_line        (wr_l1_has_line),
    .wr_dir_l1_way         (wr_dir_l1_way),
    .wr_cache_hit          (wr_cache_hit),
    .wr_is_l2_fill         (wr_is_l2_fill),
    .wr_store_sync_success (wr_store_sync_success),
    .l2rsp_packet          (l2rsp_packet),
    .l2rsp_ready           (l2rsp_ready),
    .almost_full           (almost_full),
    .overflow              (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            tests_run    = 0;
  int            tests_failed = 0;
  l2rsp_packet_t exp_q[$];
  logic          exp_af;
  logic          exp_ovf;

  task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_qualifies();
    return wr_l2req_packet.valid &&
           (wr_cache_hit || wr_is_l2_fill ||
            wr_l2req_packet.op inside {L2REQ_FLUSH, L2REQ_DINVALIDATE, L2REQ_IINVALIDATE});
  endfunction

  function automatic l2rsp_packet_t model_rsp();
    l2rsp_packet_t p;
    l2req_op_t     op;
    p  = '0;
    op = wr_l2req_packet.op;
    p.valid   = 1'b1;
    p.core    = wr_l2req_packet.core;
    p.unit    = wr_l2req_packet.unit;
    p.strand  = wr_l2req_packet.strand;
    p.address = wr_l2req_packet.address;
    p.data    = wr_data;
    p.status  = (op == L2REQ_STORE_SYNC) ? wr_store_sync_success : 1'b1;
    if (op inside {L2REQ_STORE, L2REQ_STORE_SYNC}) p.op = L2RSP_STORE_ACK;
    else if (op == L2REQ_DINVALIDATE)              p.op = L2RSP_DINVALIDATE;
    else if (op == L2REQ_IINVALIDATE)              p.op = L2RSP_IINVALIDATE;
    else                                           p.op = L2RSP_LOAD_ACK;
    if (op == L2REQ_STORE_SYNC)
      p.update = wr_store_sync_success ? wr_l1_has_line : '0;
    else if (op inside {L2REQ_STORE, L2REQ_DINVALIDATE})
      p.update = wr_l1_has_line;
    for (int c = 0; c < NUM_CORES; c++)
      p.way[c*WW +: WW] = wr_l1_has_line[c] ? wr_dir_l1_way[c*WW +: WW] : wr_l2req_packet.way;
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    l2rsp_packet_t exp_head;
    exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({tag, ".head"}, l2rsp_packet, exp_head);
    check({tag, ".almost_full"}, PKT_W'(almost_full), PKT_W'(exp_af));
    check({tag, ".overflow"}, PKT_W'(overflow), PKT_W'(exp_ovf));
  endtask

  // Check current outputs, advance the model by one clock, then step the DUT.
  task automatic tick(input string tag);
    bit            pop;
    bit            push;
    l2rsp_packet_t p;
    check_outputs(tag);
    pop  = (exp_q.size() > 0) && l2rsp_ready;
    push = model_qualifies();
    p    = model_rsp();
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(p);
`ifdef L2RSP_OVERFLOW_CHECK_EN
      else exp_ovf = 1'b1;
`endif
    end
    exp_af = (exp_q.size() >= DEPTH - SLACK);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input l2req_op_t op, input bit hit, input bit fill, input logic [31:0] addr);
    wr_l2req_packet.valid   = 1'b1;
    wr_l2req_packet.op      = op;
    wr_l2req_packet.address = addr;
    wr_l2req_packet.core    = CORE_ID_WIDTH'($urandom);
    wr_l2req_packet.unit    = UNIT_WIDTH'($urandom);
    wr_l2req_packet.strand  = STRAND_WIDTH'($urandom);
    wr_l2req_packet.way     = WW'($urandom);
    wr_data                 = {$urandom, $urandom, $urandom, $urandom};
    wr_l1_has_line          = NUM_CORES'($urandom);
    wr_dir_l1_way           = (NUM_CORES*WW)'($urandom);
    wr_store_sync_success   = 1'($urandom);
    wr_cache_hit            = hit;
    wr_is_l2_fill           = fill;
  endtask

  task automatic idle();
    wr_l2req_packet.valid = 1'b0;
    wr_cache_hit          = 1'b0;
    wr_is_l2_fill         = 1'b0;
  endtask

  logic [31:0]  burst_addr [DEPTH];
  logic [WW-1:0] saved_req_way;
  logic [NUM_CORES*WW-1:0] saved_dir;
  l2req_op_t    miss_ops [4] = '{L2REQ_LOAD, L2REQ_STORE, L2REQ_LOAD_SYNC, L2REQ_STORE_SYNC};
  int           drained;

  initial begin
    reset_n         = 1'b0;
    l2rsp_ready     = 1'b1;
    wr_l2req_packet = '0;
    wr_data         = '0;
    wr_l1_has_line  = '0;
    wr_dir_l1_way   = '0;
    wr_store_sync_success = 1'b0;
    idle();
    exp_af  = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_state");
    reset_n = 1'b1;
    tick("post_reset");

    // Load hit on an idle queue: visible the next cycle, gone the one after.
    set_req(L2REQ_LOAD, 1'b1, 1'b0, 32'h1000);
    tick("load_hit.issue");
    idle();
    check("load_hit.valid",   PKT_W'(l2rsp_packet.valid),   PKT_W'(1'b1));
    check("load_hit.op",      PKT_W'(l2rsp_packet.op),      PKT_W'(L2RSP_LOAD_ACK));
    check("load_hit.status",  PKT_W'(l2rsp_packet.status),  PKT_W'(1'b1));
    check("load_hit.update",  PKT_W'(l2rsp_packet.update),  PKT_W'(0));
    check("load_hit.address", PKT_W'(l2rsp_packet.address), PKT_W'(32'h1000));
    tick("load_hit.pop");
    check("load_hit.empty", PKT_W'(l2rsp_packet.valid), PKT_W'(1'b0));

    // STORE_SYNC failure then success.
    set_req(L2REQ_STORE_SYNC, 1'b1, 1'b0, 32'h2040);
    wr_l1_has_line        = 4'b0101;
    wr_store_sync_success = 1'b0;
    tick("ssync_fail.issue");
    idle();
    check("ssync_fail.op",     PKT_W'(l2rsp_packet.op),     PKT_W'(L2RSP_STORE_ACK));
    check("ssync_fail.status", PKT_W'(l2rsp_packet.status), PKT_W'(1'b0));
    check("ssync_fail.update", PKT_W'(l2rsp_packet.update), PKT_W'(4'b0000));
    tick("ssync_fail.pop");
    set_req(L2REQ_STORE_SYNC, 1'b1, 1'b0, 32'h2080);
    wr_l1_has_line        = 4'b0101;
    wr_store_sync_success = 1'b1;
    saved_req_way         = wr_l2req_packet.way;
    saved_dir             = wr_dir_l1_way;
    tick("ssync_ok.issue");
    idle();
    check("ssync_ok.status", PKT_W'(l2rsp_packet.status), PKT_W'(1'b1));
    check("ssync_ok.update", PKT_W'(l2rsp_packet.update), PKT_W'(4'b0101));
    check("ssync_ok.way", PKT_W'(l2rsp_packet.way),
          PKT_W'({saved_req_way, saved_dir[5:4], saved_req_way, saved_dir[1:0]}));
    tick("ssync_ok.pop");

    // Backpressure burst of five: almost_full rises once occupancy hits 5.
    l2rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      burst_addr[i] = 32'h3000 + 32'(i * 64);
      set_req(L2REQ_LOAD, 1'b1, 1'b0, burst_addr[i]);
      if (i == 4) check("burst.af_before_5th", PKT_W'(almost_full), PKT_W'(1'b0));
      tick("burst.push");
    end
    idle();
    check("burst.af_after_5th", PKT_W'(almost_full), PKT_W'(1'b1));
    tick("burst.hold");
    check("burst.head_hold", PKT_W'(l2rsp_packet.address), PKT_W'(burst_addr[0]));
    l2rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("burst.order", PKT_W'(l2rsp_packet.address), PKT_W'(burst_addr[i]));
      tick("burst.drain");
    end
    check("burst.empty", PKT_W'(l2rsp_packet.valid), PKT_W'(1'b0));

    // Full boundary: simultaneous push and pop at occupancy 8.
    l2rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(L2REQ_STORE, 1'b0, 1'b1, 32'h4000 + 32'(i * 64));
      tick("full.fill");
    end
    l2rsp_ready = 1'b1;
    set_req(L2REQ_DINVALIDATE, 1'b0, 1'b0, 32'h4800);
    tick("full.push_pop");
    idle();
    check("full.overflow", PKT_W'(overflow), PKT_W'(1'b0));
    drained = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (l2rsp_packet.valid) drained++;
      tick("full.drain");
    end
    check("full.occupancy", PKT_W'(drained), PKT_W'(DEPTH));

    // Overflow: nine pushes into a stalled queue, ninth dropped.
    l2rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      burst_addr[i % DEPTH] = (i < DEPTH) ? 32'h5000 + 32'(i * 64) : burst_addr[i % DEPTH];
      set_req(L2REQ_FLUSH, 1'b0, 1'b0, 32'h5000 + 32'(i * 64));
      tick("ovf.push");
    end
    idle();
    repeat (2) tick("ovf.hold");
`ifdef L2RSP_OVERFLOW_CHECK_EN
    check("ovf.sticky", PKT_W'(overflow), PKT_W'(1'b1));
`else
    check("ovf.tied", PKT_W'(overflow), PKT_W'(1'b0));
`endif
    l2rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf.drain_order", PKT_W'(l2rsp_packet.address), PKT_W'(burst_addr[i]));
      tick("ovf.drain");
    end
    check("ovf.empty", PKT_W'(l2rsp_packet.valid), PKT_W'(1'b0));

    // Reset mid-burst clears the queue without waiting for a clock.
    l2rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(L2REQ_IINVALIDATE, 1'b0, 1'b0, 32'h6000 + 32'(i * 64));
      tick("rst.push");
    end
    idle();
    check("rst.queued", PKT_W'(l2rsp_packet.valid), PKT_W'(1'b1));
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_af  = 1'b0;
    exp_ovf = 1'b0;
    check("rst.valid_drop", PKT_W'(l2rsp_packet.valid), PKT_W'(1'b0));
    check_outputs("rst.async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_req(miss_ops[$urandom_range(0, 3)], 1'b0, 1'b0, $urandom);
      l2rsp_ready = 1'($urandom);
      tick("miss_only");
    end
    idle();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      set_req(l2req_op_t'(3'($urandom)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), $urandom);
      wr_l2req_packet.valid = ($urandom_range(0, 3) != 0);
      l2rsp_ready           = ($urandom_range(0, 2) != 0);
      tick("random");
    end
    idle();
    l2rsp_ready = 1'b1;
    repeat (DEPTH + 1) tick("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l2_cache_response_queue.md
# l2_cache_response_queue

Parametrised L2 response stage with an output FIFO and ready/valid backpressure. Sits after the L2 writeback stage and before the L2 response interconnect. It builds one response packet per qualifying request (hit, fill, flush, invalidate) and queues it so a stalled interconnect no longer loses responses. It raises an early `almost_full` to stall the upstream L2 pipeline, and reports any overflow.

## Interface
- `NUM_CORES`, default 4: number of L1 clients; sets the widths of `update` and `way`.
- `L1_WAY_INDEX_WIDTH`, default 2: bits per L1 way index.
- `FIFO_DEPTH`, default 8: response entries; power of two, at least 2.
- `PIPE_SLACK`, default 3: in-flight requests upstream can still issue after `almost_full`; must be below `FIFO_DEPTH`.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_l2req_packet`  in  l2req_packet_t  request leaving the writeback stage.
- `wr_data`  in  CACHE_LINE_BITS  line data for the response.
- `wr_l1_has_line`  in  NUM_CORES  per-core directory hit.
- `wr_dir_l1_way`  in  NUM_CORES*L1_WAY_INDEX_WIDTH  per-core directory way.
- `wr_cache_hit`, `wr_is_l2_fill`, `wr_store_sync_success`  in  1 each  L2 lookup results.
- `l2rsp_packet`  out  l2rsp_packet_t  head of queue; `.valid` is 1 exactly when the queue is non-empty.
- `l2rsp_ready`  in  1  downstream accepts the head this cycle.
- `almost_full`  out  1  occupancy is at least FIFO_DEPTH−PIPE_SLACK.
- `overflow`  out  1  sticky; a response was dropped.

## Operation
- **Qualify.** A request qualifies when `valid` is set and at least one holds: hit, fill, op FLUSH, op DINVALIDATE, op IINVALIDATE. A miss produces nothing.
- **Op map.**
  - LOAD, LOAD_SYNC, FLUSH and any other op → LOAD_ACK.
  - STORE, STORE_SYNC → STORE_ACK.
  - DINVALIDATE → DINVALIDATE; IINVALIDATE → IINVALIDATE.
- **Fields.**
  - `status` = `wr_store_sync_success` for STORE_SYNC, else 1.
  - `core`, `unit`, `strand`, `address` and `data` pass through unchanged.
- **Update mask.**
  - STORE_SYNC: `wr_l1_has_line` ANDed with `success` replicated to all cores.
  - STORE or DINVALIDATE: `wr_l1_has_line`.
  - Otherwise: 0.
- **Way.** Per core: the directory way if that core has the line, else the request's `way`.
- **Enqueue.** A built packet is pushed at the clock edge. Pop happens on `l2rsp_packet.valid && l2rsp_ready`.
- **Full.**
  - Push while full with no pop: the packet is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both complete and occupancy is unchanged.
- **Empty.** `l2rsp_packet` is all-zero, including `.valid`. A pop while empty is ignored.
- **Order.** Strict FIFO; no reordering or merging.
- **Pointers.** Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is a (log2+1)-bit counter: +1 on push only, −1 on pop only, unchanged on both or neither.

## Timing
- **Latency.** A request qualifying in cycle N appears on `l2rsp_packet` in N+1 if the queue was empty, which matches the previous fixed stage. There is no combinational path from `wr_*` inputs to outputs.
- **Head hold.** The head is stable while `l2rsp_ready` is low.
- **Throughput.** After a pop, the next entry is visible in the following cycle, giving a sustained rate of 1 response per cycle.
- **almost_full.** Registered from the post-update occupancy, so it takes effect in the cycle after the crossing push.
- **Reset.** Asserting `reset_n` low at any time clears pointers, occupancy, `almost_full`, `overflow` and `l2rsp_packet` to 0 immediately. In-flight entries are discarded.

## Configuration
- **With `L2RSP_OVERFLOW_CHECK_EN` defined:** `overflow` behaves as above. A simulation assertion fires on any dropped push or on any push while `almost_full` has been high for more than PIPE_SLACK cycles.
- **Without it:** `overflow` is tied to 0, a push while full is silently dropped, and no assertions are compiled.

## Structure
- `l2req_packet_t`, `l2rsp_packet_t`, the op enums, `CACHE_LINE_BITS` and `NUM_CORES` stay in the shared defines/package.
- New localparams `L2RSP_PTR_WIDTH` and `L2RSP_CNT_WIDTH` are derived inside the module.
- Packet building is combinational in the top module.
- Storage goes in one sub-module, `l2_response_fifo`: a generic synchronous FIFO parametrised by width and depth that exposes count, full and empty.

## Test plan
- **Load hit, idle, ready high:** LOAD hit with address 0x1000 in cycle N → LOAD_ACK, status 1, update 0 and address 0x1000 in cycle N+1; queue empty in N+2.
- **STORE_SYNC fail:** STORE_SYNC hit, `has_line`=4'b0101, success=0 → STORE_ACK, status 0, update 4'b0000. With success=1 → update 4'b0101 and way from the directory for cores 0 and 2.
- **Backpressure burst:** ready low, 5 hits in consecutive cycles → `almost_full` high after the 5th push (occupancy 5, with 8/3). Raising ready drains the 5 packets in issue order, 1 per cycle.
- **Overflow:** ready low, 9 pushes → 9th dropped, `overflow` goes high and stays high; 8 entries drain intact.
- **Full boundary:** at occupancy 8, push and pop in the same cycle → occupancy stays 8 and `overflow` stays 0.
- **Reset mid-burst:** drive `reset_n` low with 3 entries queued → `l2rsp_packet.valid` drops immediately. After release, a miss-only input stream produces no output.
